// File: rtl/bus_sync_tx_pkg.sv
// Shared types and sizing helpers for the mux-select bus synchronizer launcher.
// State encoding and counter width used by bus_sync_tx.
package bus_sync_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        REQ,
        RELEASE
    } state_t;

    // Counter must hold both the setup count and the last timeout index.
    function automatic int cnt_width(input int setup, input int timeout);
        int m;
        m = (setup > timeout) ? setup : timeout;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/bus_sync_tx_if.sv
// Producer handshake plus CDC-side request/ack bundle of the bus launcher.
// master = launcher side, slave = producer/destination side.
interface bus_sync_tx_if #(
    parameter int BUS_WIDTH = 4
);
    logic [BUS_WIDTH-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;
    logic [BUS_WIDTH-1:0] Unsync_bus_out;
    logic                 src_bus_enable;
    logic                 dest_ack;
    logic                 tx_done;
    logic                 tx_timeout;

    modport master (
        input  tx_data, tx_valid, dest_ack,
        output tx_ready, Unsync_bus_out, src_bus_enable,
        output tx_done, tx_timeout
    );

    modport slave (
        output tx_data, tx_valid, dest_ack,
        input  tx_ready, Unsync_bus_out, src_bus_enable,
        input  tx_done, tx_timeout
    );
endinterface

// File: rtl/bus_sync_tx_bit_sync.sv
// Multi-flop level synchronizer with synchronous active-high reset.
// Brings the asynchronous destination ack into the source clock domain.
module bit_sync #(
    parameter int NUM_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);
    logic [NUM_STAGES-1:0] r_sync;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[NUM_STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[NUM_STAGES-1];
endmodule

// File: rtl/bus_sync_tx.sv
// Source-domain launcher: captures a word, holds it, raises a level request
// and completes a 4-phase req/ack handshake with the destination domain.
module bus_sync_tx
    import bus_sync_pkg::*;
#(
    parameter int BUS_WIDTH      = 4,
    parameter int NUM_STAGES     = 2,
    parameter int SETUP_CYCLES   = 1,
    parameter int TIMEOUT_CYCLES = 0
) (
    input logic          CLK,
    input logic          RST,
    bus_sync_tx_if.master bus
);
    localparam int CW = cnt_width(SETUP_CYCLES, TIMEOUT_CYCLES);
    localparam logic [CW-1:0] SETUP_LAST = CW'(SETUP_CYCLES);
    localparam logic [CW-1:0] TO_LAST    = CW'(TIMEOUT_CYCLES - 1);

    state_t               r_state, w_state;
    logic [CW-1:0]        r_cnt, w_cnt;
    logic [BUS_WIDTH-1:0] r_bus, w_bus;
    logic                 r_en, w_en;
    logic                 r_done, w_done;
    logic                 r_timeout, w_timeout;
    logic                 r_low_seen, w_low_seen;
    logic                 r_aborted, w_aborted;
    logic                 w_ack_s;
    logic                 w_ready;

    bit_sync #(.NUM_STAGES(NUM_STAGES)) u_ack_sync (
        .i_clk (CLK),
        .i_rst (RST),
        .i_d   (bus.dest_ack),
        .o_q   (w_ack_s)
    );

    assign w_ready = (r_state == IDLE) & ~RST;

    always_comb begin
        w_state    = r_state;
        w_cnt      = r_cnt;
        w_bus      = r_bus;
        w_en       = r_en;
        w_done     = 1'b0;
        w_timeout  = 1'b0;
        w_low_seen = r_low_seen;
        w_aborted  = r_aborted;
        unique case (r_state)
            IDLE: begin
                if (bus.tx_valid && w_ready) begin
                    w_bus      = bus.tx_data;
                    w_cnt      = CW'(1);
                    w_low_seen = 1'b0;
                    w_aborted  = 1'b0;
                    w_state    = SETUP;
                end
            end
            SETUP: begin
                w_low_seen = r_low_seen | ~w_ack_s;
                if (r_cnt == SETUP_LAST) begin
                    w_en    = 1'b1;
                    w_cnt   = '0;
                    w_state = REQ;
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            REQ: begin
                w_low_seen = r_low_seen | ~w_ack_s;
                // A level high since before SETUP is stale; require a low first.
                if (w_ack_s && r_low_seen) begin
                    w_en    = 1'b0;
                    w_state = RELEASE;
                end else if (TIMEOUT_CYCLES != 0 && r_cnt == TO_LAST) begin
                    w_en      = 1'b0;
                    w_timeout = 1'b1;
                    w_aborted = 1'b1;
                    w_state   = RELEASE;
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            RELEASE: begin
                if (!w_ack_s) begin
                    w_done  = ~r_aborted;
                    w_state = IDLE;
                end
            end
            default: w_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_bus      <= '0;
            r_en       <= 1'b0;
            r_done     <= 1'b0;
            r_timeout  <= 1'b0;
            r_low_seen <= 1'b0;
            r_aborted  <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_cnt      <= w_cnt;
            r_bus      <= w_bus;
            r_en       <= w_en;
            r_done     <= w_done;
            r_timeout  <= w_timeout;
            r_low_seen <= w_low_seen;
            r_aborted  <= w_aborted;
        end
    end

    assign bus.tx_ready       = w_ready;
    assign bus.Unsync_bus_out = r_bus;
    assign bus.src_bus_enable = r_en;
    assign bus.tx_done        = r_done;
    assign bus.tx_timeout     = r_timeout;
endmodule
